// File: rtl/alu_pkg.sv
// alu_pkg: shared codes for the ALU control sequencer.
// alu_op codes, ALU control codes, function-field codes and the FSM state type.
// The DIV state exists only when ALU_SEQ_DIV_EN is defined.
package alu_pkg;

    // alu_op field
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    // ALU control codes
    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SLL = 4'd3;
    localparam logic [3:0] ALU_SRL = 4'd4;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_MUL = 4'd8;
    localparam logic [3:0] ALU_DIV = 4'd9;
    localparam logic [3:0] ALU_REM = 4'd10;

    // {func7_5, func3} codes for base R-type (func7_0 = 0)
    localparam logic [3:0] FN_ADD = 4'b0000;
    localparam logic [3:0] FN_SUB = 4'b1000;
    localparam logic [3:0] FN_AND = 4'b0111;
    localparam logic [3:0] FN_OR  = 4'b0110;
    localparam logic [3:0] FN_SLT = 4'b0010;
    localparam logic [3:0] FN_SLL = 4'b0001;
    localparam logic [3:0] FN_SRL = 4'b0101;

    // func3 codes for M-extension R-type (func7_0 = 1)
    localparam logic [2:0] F3_MUL = 3'b000;
    localparam logic [2:0] F3_DIV = 3'b100;
    localparam logic [2:0] F3_REM = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
`ifdef ALU_SEQ_DIV_EN
        ST_DIV  = 2'd2,
`endif
        ST_DONE = 2'd3
    } seq_state_t;

    // True for operations that need the multi-cycle sequencer
    function automatic logic is_multi_cycle(input logic [3:0] ctrl);
        return (ctrl == ALU_MUL) || (ctrl == ALU_DIV) || (ctrl == ALU_REM);
    endfunction

endpackage

// File: rtl/alu_decode.sv
// alu_decode: purely combinational instruction-field to ALU-control decode.
// DIV/REM decode only when ALU_SEQ_DIV_EN is defined; otherwise they are illegal.
module alu_decode
    import alu_pkg::*;
(
    input  logic       valid_in,
    input  logic [1:0] alu_op,
    input  logic       func7_0,
    input  logic       func7_5,
    input  logic [2:0] func3,
    output logic [3:0] alu_control,
    output logic       illegal,
    output logic       multi_cycle,
    output logic       is_mul
);

    logic bad_enc;

    // Decode fields; undecodable R-type encodings yield control 0 and bad_enc
    always_comb begin
        alu_control = ALU_AND;
        bad_enc     = 1'b0;
        case (alu_op)
            ALUOP_ADD:   alu_control = ALU_ADD;
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_RTYPE: begin
                if (!func7_0) begin
                    case ({func7_5, func3})
                        FN_ADD:  alu_control = ALU_ADD;
                        FN_SUB:  alu_control = ALU_SUB;
                        FN_AND:  alu_control = ALU_AND;
                        FN_OR:   alu_control = ALU_OR;
                        FN_SLT:  alu_control = ALU_SLT;
                        FN_SLL:  alu_control = ALU_SLL;
                        FN_SRL:  alu_control = ALU_SRL;
                        default: bad_enc = 1'b1;
                    endcase
                end else begin
                    case (func3)
                        F3_MUL:  alu_control = ALU_MUL;
`ifdef ALU_SEQ_DIV_EN
                        F3_DIV:  alu_control = ALU_DIV;
                        F3_REM:  alu_control = ALU_REM;
`endif
                        default: bad_enc = 1'b1;
                    endcase
                end
            end
            default: alu_control = ALU_AND;  // reserved alu_op
        endcase
    end

    assign illegal     = valid_in & bad_enc;
    assign multi_cycle = is_multi_cycle(alu_control);
    assign is_mul      = (alu_control == ALU_MUL);

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: ALU control decode plus a stall/done sequencer for
// multi-cycle MUL (MUL_CYCLES) and DIV/REM (DATA_W iterations).
// Optional: define ALU_SEQ_DIV_EN to enable DIV/REM and the DIV state.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_in,
    input  logic       flush,
    input  logic       func7_0,
    input  logic       func7_5,
    input  logic [2:0] func3,
    input  logic [1:0] alu_op,
    output logic [3:0] alu_control,
    output logic       start,
    output logic       stall,
    output logic       done,
    output logic       illegal
);

    localparam int CNT_MAX = (MUL_CYCLES > DATA_W) ? MUL_CYCLES : DATA_W;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DATA_W - 1);

    seq_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       op_reg, op_next;

    logic [3:0] dec_ctrl;
    logic       dec_illegal;
    logic       dec_multi;
    logic       dec_is_mul;

    alu_decode u_decode (
        .valid_in    (valid_in),
        .alu_op      (alu_op),
        .func7_0     (func7_0),
        .func7_5     (func7_5),
        .func3       (func3),
        .alu_control (dec_ctrl),
        .illegal     (dec_illegal),
        .multi_cycle (dec_multi),
        .is_mul      (dec_is_mul)
    );

    // State, iteration counter and latched op registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            op_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
        end
    end

    // Next-state, counter and output logic; reset forces all outputs low
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        op_next     = op_reg;
        alu_control = dec_ctrl;
        start       = 1'b0;
        stall       = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                illegal  = dec_illegal;
                if (valid_in && !flush && dec_multi) begin
                    start    = 1'b1;
                    stall    = 1'b1;
                    op_next  = dec_ctrl;
                    cnt_next = dec_is_mul ? MUL_LOAD : DIV_LOAD;
`ifdef ALU_SEQ_DIV_EN
                    state_next = dec_is_mul ? ST_MUL : ST_DIV;
`else
                    state_next = ST_MUL;
`endif
                end
            end
`ifdef ALU_SEQ_DIV_EN
            ST_MUL, ST_DIV: begin
`else
            ST_MUL: begin
`endif
                alu_control = op_reg;
                stall       = 1'b1;
                if (flush) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (cnt_reg == '0) begin
                    state_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_DONE: begin
                // The retiring instruction is still presented; do not re-decode it
                alu_control = op_reg;
                done        = !flush;
                state_next  = ST_IDLE;
                cnt_next    = '0;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
        if (rst) begin
            alu_control = '0;
            start       = 1'b0;
            stall       = 1'b0;
            done        = 1'b0;
            illegal     = 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vectors with a scoreboard queue.
// Stimulus pushes one expected output record per driven cycle; a monitor pops
// and compares at the falling edge. Two DUTs share inputs: A (MUL_CYCLES=4),
// B (MUL_CYCLES=1), both DATA_W=8. DIV expectations follow ALU_SEQ_DIV_EN.
module tb_alu_sequencer;

    logic       clk = 1'b0;
    logic       rst, valid_in, flush, func7_0, func7_5;
    logic [2:0] func3;
    logic [1:0] alu_op;

    logic [3:0] ctrl_a, ctrl_b;
    logic       start_a, stall_a, done_a, ill_a;
    logic       start_b, stall_b, done_b, ill_b;

    typedef struct {
        bit         sel;
        logic [3:0] ctrl;
        logic       st;
        logic       sl;
        logic       dn;
        logic       il;
        string      nm;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.DATA_W(8), .MUL_CYCLES(4)) dut_a (
        .clk(clk), .rst(rst), .valid_in(valid_in), .flush(flush),
        .func7_0(func7_0), .func7_5(func7_5), .func3(func3), .alu_op(alu_op),
        .alu_control(ctrl_a), .start(start_a), .stall(stall_a),
        .done(done_a), .illegal(ill_a)
    );

    alu_sequencer #(.DATA_W(8), .MUL_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .valid_in(valid_in), .flush(flush),
        .func7_0(func7_0), .func7_5(func7_5), .func3(func3), .alu_op(alu_op),
        .alu_control(ctrl_b), .start(start_b), .stall(stall_b),
        .done(done_b), .illegal(ill_b)
    );

    // Monitor: compare the selected DUT against the next expected record
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [7:0] got, want;
            e    = exp_q.pop_front();
            got  = e.sel ? {ctrl_b, start_b, stall_b, done_b, ill_b}
                         : {ctrl_a, start_a, stall_a, done_a, ill_a};
            want = {e.ctrl, e.st, e.sl, e.dn, e.il};
            n_vec++;
            if (got !== want) begin
                n_miss++;
                $display("FAIL %s dut=%s got ctrl=%0d start=%b stall=%b done=%b illegal=%b, want ctrl=%0d start=%b stall=%b done=%b illegal=%b",
                         e.nm, e.sel ? "B" : "A", got[7:4], got[3], got[2], got[1], got[0],
                         want[7:4], want[3], want[2], want[1], want[0]);
            end else begin
                $display("vec %0d %s dut=%s ctrl=%0d start=%b stall=%b done=%b illegal=%b ok",
                         n_vec, e.nm, e.sel ? "B" : "A", got[7:4], got[3], got[2], got[1], got[0]);
            end
        end
    end

    // Drive one cycle of inputs and push the expected outputs for that cycle
    task automatic step(input logic r, input logic v, input logic fl, input logic [1:0] op,
                        input logic f70, input logic f75, input logic [2:0] f3, input bit sel,
                        input logic [3:0] ec, input logic es, input logic esl,
                        input logic ed, input logic ei, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; valid_in = v; flush = fl; alu_op = op;
        func7_0 = f70; func7_5 = f75; func3 = f3;
        e.sel = sel; e.ctrl = ec; e.st = es; e.sl = esl; e.dn = ed; e.il = ei; e.nm = nm;
        exp_q.push_back(e);
    endtask

    // Quiet cycle: alu_op=00 decodes as ADD in IDLE, nothing else asserted
    task automatic idle_chk(input bit sel, input string nm);
        step(0, 0, 0, 2'b00, 0, 0, 3'b000, sel, 4'd2, 0, 0, 0, 0, nm);
    endtask

    // Single-cycle base R-type on DUT A
    task automatic rtype(input logic f75, input logic [2:0] f3, input logic [3:0] ec,
                         input logic ei, input string nm);
        step(0, 1, 0, 2'b10, 0, f75, f3, 0, ec, 0, 0, 0, ei, nm);
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; flush = 1'b0; alu_op = 2'b00;
        func7_0 = 1'b0; func7_5 = 1'b0; func3 = 3'b000;

        // Reset holds every output low even with a valid MUL presented
        step(1, 1, 0, 2'b10, 1, 0, 3'b000, 0, 4'd0, 0, 0, 0, 0, "rst_a");
        step(1, 1, 1, 2'b10, 1, 0, 3'b000, 1, 4'd0, 0, 0, 0, 0, "rst_b");

        // Single-cycle decode
        rtype(0, 3'b000, 4'd2, 0, "add");
        rtype(1, 3'b000, 4'd6, 0, "sub");
        rtype(0, 3'b111, 4'd0, 0, "and");
        rtype(0, 3'b110, 4'd1, 0, "or");
        rtype(0, 3'b010, 4'd7, 0, "slt");
        rtype(0, 3'b001, 4'd3, 0, "sll");
        rtype(0, 3'b101, 4'd4, 0, "srl");
        rtype(1, 3'b111, 4'd0, 1, "ill_base");
        step(0, 1, 0, 2'b00, 0, 0, 3'b000, 0, 4'd2, 0, 0, 0, 0, "aluop_add");
        step(0, 1, 0, 2'b01, 0, 0, 3'b000, 0, 4'd6, 0, 0, 0, 0, "aluop_sub");
        step(0, 1, 0, 2'b11, 0, 0, 3'b000, 0, 4'd0, 0, 0, 0, 0, "aluop_rsvd");
        step(0, 1, 0, 2'b10, 1, 0, 3'b001, 0, 4'd0, 0, 0, 0, 1, "ill_m001");
        step(0, 0, 0, 2'b10, 0, 1, 3'b111, 0, 4'd0, 0, 0, 0, 0, "ill_novalid");

        // MUL, MUL_CYCLES=4: start T0, stall T0..T4, done T5, latched op throughout
        step(0, 1, 0, 2'b10, 1, 0, 3'b000, 0, 4'd8, 1, 1, 0, 0, "mul_t0");
        for (int i = 0; i < 4; i++)
            step(0, 0, 0, 2'b00, 0, 0, 3'b000, 0, 4'd8, 0, 1, 0, 0, "mul_busy");
        step(0, 1, 0, 2'b10, 0, 0, 3'b000, 0, 4'd8, 0, 0, 1, 0, "mul_done");
        rtype(0, 3'b000, 4'd2, 0, "add_after_mul");

        // Flush on the third MUL cycle: back to IDLE, ADD decodes at once, no done
        step(0, 1, 0, 2'b10, 1, 0, 3'b000, 0, 4'd8, 1, 1, 0, 0, "fl_mul_t0");
        step(0, 0, 0, 2'b00, 0, 0, 3'b000, 0, 4'd8, 0, 1, 0, 0, "fl_mul_t1");
        step(0, 0, 1, 2'b00, 0, 0, 3'b000, 0, 4'd8, 0, 1, 0, 0, "fl_mul_t2");
        rtype(0, 3'b000, 4'd2, 0, "add_after_flush");
        idle_chk(0, "no_done_1");
        idle_chk(0, "no_done_2");
        idle_chk(0, "no_done_3");

        // Flush in IDLE suppresses start
        step(0, 1, 1, 2'b10, 1, 0, 3'b000, 0, 4'd8, 0, 0, 0, 0, "flush_idle");
        idle_chk(0, "flush_idle_next");

`ifdef ALU_SEQ_DIV_EN
        // DIV, DATA_W=8: stall 9 cycles, done on the 10th
        step(0, 1, 0, 2'b10, 1, 0, 3'b100, 0, 4'd9, 1, 1, 0, 0, "div_t0");
        for (int i = 0; i < 8; i++)
            step(0, 0, 0, 2'b00, 0, 0, 3'b000, 0, 4'd9, 0, 1, 0, 0, "div_busy");
        step(0, 1, 0, 2'b10, 1, 0, 3'b100, 0, 4'd9, 0, 0, 1, 0, "div_done");
        idle_chk(0, "div_idle");

        // Reset mid-REM
        step(0, 1, 0, 2'b10, 1, 0, 3'b110, 0, 4'd10, 1, 1, 0, 0, "rem_t0");
        step(0, 0, 0, 2'b00, 0, 0, 3'b000, 0, 4'd10, 0, 1, 0, 0, "rem_busy");
        step(0, 0, 0, 2'b00, 0, 0, 3'b000, 0, 4'd10, 0, 1, 0, 0, "rem_busy");
        step(1, 1, 1, 2'b10, 1, 0, 3'b110, 0, 4'd0, 0, 0, 0, 0, "rst_mid_rem");
        idle_chk(0, "rst_mid_idle");
`else
        // Without divide support DIV/REM are illegal and never stall
        step(0, 1, 0, 2'b10, 1, 0, 3'b100, 0, 4'd0, 0, 0, 0, 1, "div_illegal");
        idle_chk(0, "div_idle");
        step(0, 1, 0, 2'b10, 1, 0, 3'b110, 0, 4'd0, 0, 0, 0, 1, "rem_illegal");
        idle_chk(0, "rem_idle");

        // Reset mid-MUL
        step(0, 1, 0, 2'b10, 1, 0, 3'b000, 0, 4'd8, 1, 1, 0, 0, "rmul_t0");
        step(0, 0, 0, 2'b00, 0, 0, 3'b000, 0, 4'd8, 0, 1, 0, 0, "rmul_busy");
        step(1, 1, 1, 2'b10, 1, 0, 3'b000, 0, 4'd0, 0, 0, 0, 0, "rst_mid_mul");
        idle_chk(0, "rst_mid_idle");
`endif

        // DUT B, MUL_CYCLES=1: stall exactly 2 cycles then done
        step(1, 0, 0, 2'b00, 0, 0, 3'b000, 1, 4'd0, 0, 0, 0, 0, "b_rst");
        step(0, 1, 0, 2'b10, 1, 0, 3'b000, 1, 4'd8, 1, 1, 0, 0, "b_mul_t0");
        step(0, 0, 0, 2'b00, 0, 0, 3'b000, 1, 4'd8, 0, 1, 0, 0, "b_mul_t1");
        step(0, 0, 0, 2'b00, 0, 0, 3'b000, 1, 4'd8, 0, 0, 1, 0, "b_mul_done");
        idle_chk(1, "b_idle");

        // Let the monitor drain the queue, bounded
        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            n_miss++;
            $display("FAIL drain: %0d expected records left, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand width; sets the divide iteration count.
REQ-002 SHALL have parameter MUL_CYCLES, default 4: multiplier latency in cycles; legal range 1..DATA_W.
REQ-003 SHALL have port clk  input  1  clock, single clock domain.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port valid_in  input  1  an instruction is presented this cycle.
REQ-006 SHALL have port flush  input  1  kill the in-flight operation.
REQ-007 SHALL have port func7_0  input  1  M-extension select bit.
REQ-008 SHALL have port func7_5  input  1  sub/alt select bit.
REQ-009 SHALL have port func3  input  3  function field.
REQ-010 SHALL have port alu_op  input  2  00 add, 01 sub, 10 R-type, 11 reserved.
REQ-011 SHALL have port alu_control  output  4  ALU operation code.
REQ-012 SHALL have ports start, stall, done, illegal  output  1 each: multi-cycle start pulse, pipeline hold, completion pulse, undecodable R-type.

Function
REQ-013 SHALL use ALU codes AND 0, OR 1, ADD 2, SLL 3, SRL 4, SUB 6, SLT 7, MUL 8, DIV 9, REM 10.
REQ-014 SHALL decode R-type with func7_0=0 as {func7_5,func3}: 0000 ADD, 1000 SUB, 0111 AND, 0110 OR, 0010 SLT, 0001 SLL, 0101 SRL.
REQ-015 SHALL decode R-type with func7_0=1 as func3: 000 MUL, 100 DIV, 110 REM; every other R-type encoding SHALL give alu_control=0 and illegal=1 (combinational, only when valid_in).
REQ-016 SHALL use FSM states IDLE, MUL, DIV, DONE.
REQ-017 In IDLE, alu_control SHALL be the combinational decode; single-cycle ops SHALL not stall and the FSM SHALL stay in IDLE.
REQ-018 In IDLE with valid_in and a MUL/DIV/REM decode, the FSM SHALL assert stall and start combinationally, latch the op, load the counter (MUL_CYCLES-1 for MUL, DATA_W-1 for DIV/REM), and enter MUL or DIV.
REQ-019 In MUL/DIV, the FSM SHALL assert stall, decrement the counter each cycle, and enter DONE on the cycle the counter is 0.
REQ-020 In DONE, the FSM SHALL assert done for one cycle, deassert stall, ignore valid_in (the same instruction is retiring), and return to IDLE.
REQ-021 In MUL, DIV and DONE, alu_control SHALL be the latched op, independent of inputs.
REQ-022 Total stall SHALL be 1+MUL_CYCLES cycles for MUL and 1+DATA_W cycles for DIV/REM.
REQ-023 flush SHALL force IDLE next cycle with no done; flush has priority over valid_in, and a flush in IDLE SHALL suppress start.
REQ-024 The counter SHALL be $clog2(max(MUL_CYCLES,DATA_W)) bits, never underflow, and hold 0 in IDLE.

Reset
REQ-025 rst SHALL force IDLE, counter 0 and latched op 0; start, stall, done and illegal SHALL be 0 while rst=1, and rst SHALL override flush and valid_in.

Configuration
REQ-026 Macro ALU_SEQ_DIV_EN defined: DIV/REM decoding and the DIV state SHALL be present; undefined: func7_0=1 with func3 100/110 SHALL decode as illegal (alu_control 0, no stall) and the DIV state SHALL be absent.

Structure
REQ-027 Package alu_pkg SHALL hold the alu_op codes, ALU control codes, function-field codes and the FSM state type.
REQ-028 The combinational decode SHALL be sub-module alu_decode; the FSM and counter SHALL stay in alu_sequencer.

Verification
REQ-029 ADD: alu_op=10, {0,0,000}, valid -> alu_control=2 same cycle, stall=0, start=0.
REQ-030 MUL with MUL_CYCLES=4: func7_0=1, func3=000 -> start=1 at T0, stall T0..T4, done=1 at T5, alu_control=8 T0..T5.
REQ-031 DIV with DATA_W=8 and ALU_SEQ_DIV_EN: func3=100 -> stall 9 cycles, done on cycle 10; without the macro -> illegal=1, stall=0.
REQ-032 flush on the third MUL cycle -> IDLE next cycle, no done, a following ADD decodes immediately.
REQ-033 rst asserted mid-DIV -> next cycle all outputs 0 and IDLE; MUL_CYCLES=1 -> stall exactly 2 cycles.
